// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store sequencer in front of the
// shared-bus word memory. Each access is held ACC_CYCLES clocks so both of
// the memory's free-running fetch phases see stable controls. Halfword
// stores are issued as two byte stores (low byte at addr, high byte at
// addr+1). Load data is sign/zero extended on the way back.
module mem_access_ctrl #(
    parameter int unsigned ACC_CYCLES = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic [1:0]  mem_write,
    output logic [31:0] mem_addr,
    inout  wire  [31:0] bus
);

    typedef enum logic [2:0] {IDLE, RD, WR, WR_HI, RESP} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} size_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_CYCLES - 1);

    state_t           state;
    size_t            size_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic [7:0]       hi_byte;
    logic             we_q;
    logic             uns_q;
    logic             err_q;
    logic [31:0]      raw;
    logic [31:0]      ext;
    logic             drive;
    logic [31:0]      bus_out;

    // drive enable is a flop with async reset, so the bus releases the
    // instant rst rises
    assign bus = drive ? bus_out : 'z;

    // extend the sampled load word according to the latched size/signedness
    always_comb begin
        ext = raw;
        case (size_q)
            SZ_BYTE: ext = uns_q ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            SZ_HALF: ext = uns_q ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

    // sequencer: all handshake and memory controls are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            size_q     <= SZ_BYTE;
            cnt        <= '0;
            addr_q     <= '0;
            hi_byte    <= '0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            err_q      <= 1'b0;
            raw        <= '0;
            drive      <= 1'b0;
            bus_out    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 2'd0;
            mem_addr   <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_valid) begin
                        size_q    <= size_t'(req_size);
                        addr_q    <= req_addr;
                        hi_byte   <= req_wdata[15:8];
                        we_q      <= req_we;
                        uns_q     <= req_unsigned;
                        err_q     <= (size_t'(req_size) == SZ_BAD);
                        req_ready <= 1'b0;
                        if (size_t'(req_size) == SZ_BAD) begin
                            state <= RESP;
                        end else if (!req_we) begin
                            state    <= RD;
                            mem_read <= 1'b1;
                            mem_addr <= req_addr;
                        end else begin
                            state     <= WR;
                            mem_addr  <= req_addr;
                            drive     <= 1'b1;
                            if (size_t'(req_size) == SZ_WORD) begin
                                mem_write <= 2'd1;
                                bus_out   <= req_wdata;
                            end else begin
                                mem_write <= 2'd3;
                                bus_out   <= {24'b0, req_wdata[7:0]};
                            end
                        end
                    end
                end
                RD: begin
                    if (cnt == LAST) begin
                        raw      <= bus;
                        mem_read <= 1'b0;
                        cnt      <= '0;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (size_q == SZ_HALF) begin
                            state    <= WR_HI;
                            mem_addr <= addr_q + 32'd1;
                            bus_out  <= {24'b0, hi_byte};
                        end else begin
                            state     <= RESP;
                            mem_write <= 2'd0;
                            drive     <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_HI: begin
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        state     <= RESP;
                        mem_write <= 2'd0;
                        drive     <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b1;
                    resp_err   <= err_q;
                    resp_rdata <= (err_q || we_q) ? '0 : ext;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a byte-array model of the
// shared-bus memory. Stimulus pushes expected responses and per-cycle
// memory accesses; a negedge monitor pops and compares them.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic [1:0]  mem_write;
    logic [31:0] mem_addr;
    wire  [31:0] bus;

    mem_access_ctrl #(.ACC_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // memory model: 256 bytes, address wraps on 8 bits
    logic [7:0]  mem [0:255];
    logic [7:0]  a0, a1, a2, a3;
    logic [31:0] rdword;
    logic        pre;
    logic        probe_en;

    always_comb begin
        a0 = mem_addr[7:0];
        a1 = a0 + 8'd1;
        a2 = a0 + 8'd2;
        a3 = a0 + 8'd3;
        rdword = {mem[a3], mem[a2], mem[a1], mem[a0]};
    end

    assign bus = probe_en ? 32'h5A5A5A5A : (mem_read ? rdword : 'z);

    always @(posedge clk) begin
        if (pre) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'hAA;
            mem[8'h11] <= 8'hBB;
            mem[8'h12] <= 8'hCC;
            mem[8'h13] <= 8'hDD;
        end else if (mem_write == 2'd1) begin
            mem[a0] <= bus[7:0];
            mem[a1] <= bus[15:8];
            mem[a2] <= bus[23:16];
            mem[a3] <= bus[31:24];
        end else if (mem_write == 2'd3) begin
            mem[a0] <= bus[7:0];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
        int unsigned acc;
    } resp_t;

    typedef struct {
        logic        mr;
        logic [1:0]  mw;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk;
    } acc_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] want;
    } chk_t;

    resp_t rq[$];
    acc_t  aq[$];
    chk_t  cq[$];

    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic        done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    resp_t re;
    acc_t  ae;
    chk_t  ce;

    // monitor: all comparisons happen here
    always @(negedge clk) begin
        while (cq.size() != 0) begin
            ce = cq.pop_front();
            n_cmp = n_cmp + 1;
            if (ce.act !== ce.want) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: got %h want %h", ce.name, ce.act, ce.want);
            end
        end
        if (!rst && !done) begin
            if (resp_valid) begin
                n_cmp = n_cmp + 1;
                if (rq.size() == 0) begin
                    n_bad = n_bad + 1;
                    $display("FAIL unexpected_resp: got rdata=%h err=%b want none", resp_rdata, resp_err);
                end else begin
                    re = rq.pop_front();
                    if (resp_rdata !== re.rdata || resp_err !== re.err || (cyc - re.acc) != re.lat) begin
                        n_bad = n_bad + 1;
                        $display("FAIL resp: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                                 resp_rdata, resp_err, cyc - re.acc, re.rdata, re.err, re.lat);
                    end
                end
            end
            if (mem_read || mem_write != 2'd0) begin
                n_cmp = n_cmp + 1;
                if (aq.size() == 0) begin
                    n_bad = n_bad + 1;
                    $display("FAIL unexpected_access: got rd=%b wr=%0d addr=%h want none",
                             mem_read, mem_write, mem_addr);
                end else begin
                    ae = aq.pop_front();
                    if (mem_read !== ae.mr || mem_write !== ae.mw || mem_addr !== ae.addr ||
                        (ae.chk && bus !== ae.data)) begin
                        n_bad = n_bad + 1;
                        $display("FAIL access: got rd=%b wr=%0d addr=%h bus=%h want rd=%b wr=%0d addr=%h bus=%h",
                                 mem_read, mem_write, mem_addr, bus, ae.mr, ae.mw, ae.addr, ae.data);
                    end
                end
            end
        end
        if (done) begin
            n_cmp = n_cmp + 1;
            if (rq.size() != 0 || aq.size() != 0) begin
                n_bad = n_bad + 1;
                $display("FAIL drain: got %0d resp / %0d access pending want 0 / 0", rq.size(), aq.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    task automatic push_acc(input logic mr, input logic [1:0] mw, input logic [31:0] addr,
                            input logic [31:0] data, input logic chk, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) aq.push_back('{mr, mw, addr, data, chk});
    endtask

    task automatic wait_ready();
        int unsigned n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) cq.push_back('{"ready_timeout", 32'(req_ready), 32'd1});
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int unsigned lat);
        wait_ready();
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        rq.push_back('{exp_rdata, exp_err, lat, cyc + 1});
        if (!exp_err) begin
            if (!we)               push_acc(1'b1, 2'd0, addr, 32'd0, 1'b0, 4);
            else if (size == 2'd2) push_acc(1'b0, 2'd1, addr, wdata, 1'b1, 4);
            else begin
                push_acc(1'b0, 2'd3, addr, {24'b0, wdata[7:0]}, 1'b1, 4);
                if (size == 2'd1) push_acc(1'b0, 2'd3, addr + 32'd1, {24'b0, wdata[15:8]}, 1'b1, 4);
            end
        end
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = ~we;
        req_size     = 2'd3;
        req_unsigned = ~uns;
        req_addr     = 32'hDEAD_BEEF;
        req_wdata    = $urandom;
    endtask

    initial begin
        rst = 1'b1; pre = 1'b1; probe_en = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 pre = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        probe_en = 1'b1;
        #1;
        cq.push_back('{"rst_req_ready", 32'(req_ready), 32'd1});
        cq.push_back('{"rst_resp_valid", 32'(resp_valid), 32'd0});
        cq.push_back('{"rst_resp_err", 32'(resp_err), 32'd0});
        cq.push_back('{"rst_resp_rdata", resp_rdata, 32'd0});
        cq.push_back('{"rst_mem_read", 32'(mem_read), 32'd0});
        cq.push_back('{"rst_mem_write", 32'(mem_write), 32'd0});
        cq.push_back('{"rst_mem_addr", mem_addr, 32'd0});
        cq.push_back('{"rst_bus_released", bus, 32'h5A5A5A5A});
        probe_en = 1'b0;

        //    we    size  uns   addr          wdata         rdata         err   lat
        issue(1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'hDDCCBBAA, 1'b0, 5);
        issue(1'b1, 2'd0, 1'b0, 32'h13,       32'h12345680, 32'h0,        1'b0, 5);
        issue(1'b0, 2'd0, 1'b0, 32'h13,       32'h0,        32'hFFFFFF80, 1'b0, 5);
        issue(1'b0, 2'd0, 1'b1, 32'h13,       32'h0,        32'h00000080, 1'b0, 5);
        issue(1'b0, 2'd1, 1'b0, 32'h12,       32'h0,        32'hFFFF80CC, 1'b0, 5);
        issue(1'b1, 2'd1, 1'b0, 32'h21,       32'h1234ABCD, 32'h0,        1'b0, 9);
        issue(1'b0, 2'd1, 1'b0, 32'h21,       32'h0,        32'hFFFFABCD, 1'b0, 5);
        issue(1'b0, 2'd2, 1'b0, 32'h20,       32'h0,        32'h00ABCD00, 1'b0, 5);
        issue(1'b1, 2'd2, 1'b0, 32'h0E,       32'hCAFEBABE, 32'h0,        1'b0, 5);
        issue(1'b0, 2'd2, 1'b0, 32'h0E,       32'h0,        32'hCAFEBABE, 1'b0, 5);
        issue(1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'h80CCCAFE, 1'b0, 5);
        issue(1'b1, 2'd3, 1'b0, 32'h50,       32'hFFFFFFFF, 32'h0,        1'b1, 1);
        issue(1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h00005566, 32'h0,        1'b0, 9);
        issue(1'b0, 2'd1, 1'b1, 32'hFFFFFFFF, 32'h0,        32'h00005566, 1'b0, 5);
        issue(1'b0, 2'd0, 1'b0, 32'h00,       32'h0,        32'h00000055, 1'b0, 5);

        // reset in the second WR cycle of a word store: no response expected
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h11223344;
        push_acc(1'b0, 2'd1, 32'h40, 32'h11223344, 1'b1, 2);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        probe_en = 1'b1;
        rst = 1'b1;
        #1;
        cq.push_back('{"midrst_mem_write", 32'(mem_write), 32'd0});
        cq.push_back('{"midrst_mem_read", 32'(mem_read), 32'd0});
        cq.push_back('{"midrst_bus_released", bus, 32'h5A5A5A5A});
        cq.push_back('{"midrst_resp_valid", 32'(resp_valid), 32'd0});
        probe_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        cq.push_back('{"postrst_req_ready", 32'(req_ready), 32'd1});

        issue(1'b0, 2'd2, 1'b0, 32'h0E,       32'h0,        32'hCAFEBABE, 1'b0, 5);

        for (int i = 0; i < 40 && (rq.size() != 0 || aq.size() != 0); i++) @(negedge clk);
        @(posedge clk);
        done = 1'b1;
    end

endmodule
